// File: rtl/btb_predictor.sv
// btb_predictor: tagged branch target buffer with per-entry saturating counters.
// Lookup is combinational; training from writeback lands on the clock edge.
// After reset a clear sequence walks every entry and invalidates it (busy_o=1).
// Optional feature macro: BTB_FWD_EN -- a same-cycle update to the looked-up
// idx/tag is forwarded to the lookup outputs instead of appearing next cycle.
module btb_predictor #(
  parameter int PC_W  = 16,
  parameter int IDX_W = 10,
  parameter int TAG_W = 5,
  parameter int CTR_W = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [PC_W-1:0] lk_pc_i,
  output logic [PC_W-1:0] lk_next_o,
  output logic            lk_hit_o,
  output logic            lk_taken_o,
  input  logic            upd_en_i,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [PC_W-1:0] upd_target_i,
  output logic            busy_o
);

  localparam int N = 1 << IDX_W;
  localparam logic [IDX_W-1:0] CLR_LAST = '1;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] clr_ptr_q;
  logic             busy_q;

  // Entry = {valid, tag, target, ctr}; valid kept as a vector so the clear
  // sequence only touches one bit per entry.
  logic [N-1:0]     valid_q;
  logic [TAG_W-1:0] tag_q [N];
  logic [PC_W-1:0]  tgt_q [N];
  logic [CTR_W-1:0] ctr_q [N];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_fire, upd_hit, upd_we;
  logic [CTR_W-1:0] ctr_d;
  logic [PC_W-1:0]  tgt_d;

  logic             ent_valid;
  logic [TAG_W-1:0] ent_tag;
  logic [PC_W-1:0]  ent_tgt;
  logic [CTR_W-1:0] ent_ctr;
  logic             hit, taken;

  // Bit 0 and bits above the tag are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc_i, upd_pc_i};

  assign lk_idx  = lk_pc_i[IDX_W:1];
  assign lk_tag  = lk_pc_i[IDX_W+TAG_W:IDX_W+1];
  assign upd_idx = upd_pc_i[IDX_W:1];
  assign upd_tag = upd_pc_i[IDX_W+TAG_W:IDX_W+1];

  // Training decision: counter step on hit, weakly-taken allocation on taken miss.
  always_comb begin
    upd_fire = upd_en_i & ~busy_q & ~rst_i;
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_we   = upd_fire && (upd_hit || upd_taken_i);
    ctr_d    = CTR_WEAK;
    if (upd_hit) begin
      if (upd_taken_i)
        ctr_d = (ctr_q[upd_idx] == CTR_MAX) ? CTR_MAX : ctr_q[upd_idx] + CTR_W'(1);
      else
        ctr_d = (ctr_q[upd_idx] == '0) ? '0 : ctr_q[upd_idx] - CTR_W'(1);
    end
    tgt_d = upd_taken_i ? upd_target_i : tgt_q[upd_idx];
  end

  // Lookup path: read the indexed entry, optionally replaced by the in-flight update.
  always_comb begin
    ent_valid = valid_q[lk_idx];
    ent_tag   = tag_q[lk_idx];
    ent_tgt   = tgt_q[lk_idx];
    ent_ctr   = ctr_q[lk_idx];
`ifdef BTB_FWD_EN
    if (upd_we && (upd_idx == lk_idx) && (upd_tag == lk_tag)) begin
      ent_valid = 1'b1;
      ent_tag   = upd_tag;
      ent_tgt   = tgt_d;
      ent_ctr   = ctr_d;
    end
`endif
    hit        = ~busy_q && ent_valid && (ent_tag == lk_tag);
    taken      = hit && ent_ctr[CTR_W-1];
    lk_hit_o   = hit;
    lk_taken_o = taken;
    lk_next_o  = taken ? ent_tgt : lk_pc_i + PC_W'(2);
  end

  assign busy_o = busy_q;

  // Clear/run sequencer; owns the valid bits (cleared in CLEAR, set on allocation).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          valid_q[clr_ptr_q] <= 1'b0;
          clr_ptr_q          <= clr_ptr_q + IDX_W'(1);
          if (clr_ptr_q == CLR_LAST) begin
            state_q <= S_RUN;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (upd_we) valid_q[upd_idx] <= 1'b1;
        end
      endcase
    end
  end

  // Entry payload write; contents of invalid entries are don't-care so no reset.
  always_ff @(posedge clk_i) begin
    if (upd_we) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= tgt_d;
      ctr_q[upd_idx] <= ctr_d;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor (PC_W=16, IDX_W=4, TAG_W=3, CTR_W=2) against a
// table-of-entries reference model; define BTB_FWD_EN to bench the forwarding build.
module tb_btb_predictor;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] lk_pc = 16'h0, upd_pc = 16'h0, upd_target = 16'h0;
  logic        upd_en = 1'b0, upd_taken = 1'b0;
  logic [15:0] lk_next;
  logic        lk_hit, lk_taken, busy;

  always #5 clk = ~clk;

  btb_predictor #(.PC_W(16), .IDX_W(4), .TAG_W(3), .CTR_W(2)) dut (
    .clk_i(clk), .rst_i(rst), .lk_pc_i(lk_pc), .lk_next_o(lk_next),
    .lk_hit_o(lk_hit), .lk_taken_o(lk_taken), .upd_en_i(upd_en),
    .upd_pc_i(upd_pc), .upd_taken_i(upd_taken), .upd_target_i(upd_target),
    .busy_o(busy));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one record per table slot plus remaining clear cycles.
  bit          m_valid [N];
  int          m_tag   [N];
  logic [15:0] m_tgt   [N];
  int          m_ctr   [N];
  int          m_clear_left = 16;

  function automatic int idx_of(input logic [15:0] pc);
    return (int'(pc) / 2) % N;
  endfunction

  function automatic int tag_of(input logic [15:0] pc);
    return (int'(pc) / 32) % 8;
  endfunction

  task automatic train(inout bit v, inout int t, inout logic [15:0] tg, inout int c,
                       input logic [15:0] pc, input logic tk, input logic [15:0] target);
    if (v && t == tag_of(pc)) begin
      if (tk) begin
        c  = (c < 3) ? c + 1 : 3;
        tg = target;
      end else begin
        c = (c > 0) ? c - 1 : 0;
      end
    end else if (tk) begin
      v = 1'b1; t = tag_of(pc); tg = target; c = 2;
    end
  endtask

  task automatic expect_lookup(output logic eh, output logic et, output logic [15:0] en);
    int i = idx_of(lk_pc);
    bit v = m_valid[i];
    int t = m_tag[i];
    logic [15:0] tg = m_tgt[i];
    int c = m_ctr[i];
`ifdef BTB_FWD_EN
    if (!rst && upd_en && m_clear_left == 0 && idx_of(upd_pc) == i && tag_of(upd_pc) == tag_of(lk_pc))
      train(v, t, tg, c, upd_pc, upd_taken, upd_target);
`endif
    eh = (m_clear_left == 0) && v && (t == tag_of(lk_pc));
    et = eh && (c >= 2);
    en = et ? tg : lk_pc + 16'd2;
  endtask

  task automatic tick();
    int i; bit v; int t; int c; logic [15:0] tg;
    @(posedge clk);
    if (rst) begin
      m_clear_left = 16;
      for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
    end else if (upd_en) begin
      i = idx_of(upd_pc); v = m_valid[i]; t = m_tag[i]; tg = m_tgt[i]; c = m_ctr[i];
      train(v, t, tg, c, upd_pc, upd_taken, upd_target);
      m_valid[i] = v; m_tag[i] = t; m_tgt[i] = tg; m_ctr[i] = c;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] lp, input logic ue, input logic [15:0] up,
                       input logic ut, input logic [15:0] utg);
    lk_pc = lp; upd_en = ue; upd_pc = up; upd_taken = ut; upd_target = utg;
  endtask

  task automatic test_reset();
    logic eh, et; logic [15:0] en; int cnt = 0;
    drive(16'h0010, 1'b0, 16'h0, 1'b0, 16'h0);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1; expect_lookup(eh, et, en);
      n_checks++;
      if ({busy, lk_hit, lk_taken, lk_next} !== {m_clear_left > 0, eh, et, en}) begin
        n_fail++;
        $display("FAIL reset_model cyc %0d: got busy=%b hit=%b tk=%b next=%h want %b %b %b %h",
                 k, busy, lk_hit, lk_taken, lk_next, m_clear_left > 0, eh, et, en);
      end
      n_checks++;
      if ({lk_hit, lk_next} !== {1'b0, 16'h0012}) begin
        n_fail++;
        $display("FAIL reset_lookup cyc %0d: got hit=%b next=%h want 0 0012", k, lk_hit, lk_next);
      end
      if (busy !== 1'b1) break;
      cnt++;
      tick();
    end
    n_checks++;
    if (cnt !== 16) begin
      n_fail++;
      $display("FAIL reset_busy_len: got %0d cycles want 16", cnt);
    end
  endtask

  task automatic test_allocate();
    logic eh, et; logic [15:0] en;
    drive(16'h0024, 1'b1, 16'h0024, 1'b1, 16'h0100);
    #1; expect_lookup(eh, et, en);
    n_checks++;
    if ({lk_hit, lk_taken, lk_next} !== {eh, et, en}) begin
      n_fail++;
      $display("FAIL alloc_same_cycle: got %b %b %h want %b %b %h", lk_hit, lk_taken, lk_next, eh, et, en);
    end
    tick();
    drive(16'h0024, 1'b0, 16'h0, 1'b0, 16'h0);
    #1;
    n_checks++;
    if ({lk_hit, lk_taken, lk_next} !== {1'b1, 1'b1, 16'h0100}) begin
      n_fail++;
      $display("FAIL alloc_hit: got %b %b %h want 1 1 0100", lk_hit, lk_taken, lk_next);
    end
    tick();
  endtask

  task automatic test_hysteresis();
    bit tk_seq  [9] = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
    bit exp_tk  [9] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [15:0] en;
    for (int s = 0; s < 9; s++) begin
      drive(16'h0000, 1'b1, 16'h0024, tk_seq[s], 16'h0100);
      tick();
      drive(16'h0024, 1'b0, 16'h0, 1'b0, 16'h0);
      #1;
      en = exp_tk[s] ? 16'h0100 : 16'h0026;
      n_checks++;
      if ({lk_hit, lk_taken, lk_next} !== {1'b1, exp_tk[s], en}) begin
        n_fail++;
        $display("FAIL hyst step %0d: got %b %b %h want 1 %b %h", s, lk_hit, lk_taken, lk_next, exp_tk[s], en);
      end
    end
  endtask

  task automatic test_alias();
    drive(16'h0044, 1'b0, 16'h0, 1'b0, 16'h0);
    #1;
    n_checks++;
    if ({lk_hit, lk_taken, lk_next} !== {1'b0, 1'b0, 16'h0046}) begin
      n_fail++;
      $display("FAIL alias_miss: got %b %b %h want 0 0 0046", lk_hit, lk_taken, lk_next);
    end
    drive(16'h0000, 1'b1, 16'h0044, 1'b1, 16'h0200);
    tick();
    drive(16'h0024, 1'b0, 16'h0, 1'b0, 16'h0);
    #1;
    n_checks++;
    if ({lk_hit, lk_next} !== {1'b0, 16'h0026}) begin
      n_fail++;
      $display("FAIL alias_evicted: got %b %h want 0 0026", lk_hit, lk_next);
    end
    lk_pc = 16'h0044;
    #1;
    n_checks++;
    if ({lk_hit, lk_taken, lk_next} !== {1'b1, 1'b1, 16'h0200}) begin
      n_fail++;
      $display("FAIL alias_new: got %b %b %h want 1 1 0200", lk_hit, lk_taken, lk_next);
    end
    tick();
  endtask

  task automatic test_wrap();
    drive(16'hFFFE, 1'b1, 16'h0050, 1'b0, 16'h0300);
    #1;
    n_checks++;
    if ({lk_hit, lk_taken, lk_next} !== {1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL wrap: got %b %b %h want 0 0 0000", lk_hit, lk_taken, lk_next);
    end
    tick();
    drive(16'h0050, 1'b0, 16'h0, 1'b0, 16'h0);
    #1;
    n_checks++;
    if ({lk_hit, lk_next} !== {1'b0, 16'h0052}) begin
      n_fail++;
      $display("FAIL nt_miss_no_alloc: got %b %h want 0 0052", lk_hit, lk_next);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    logic [17:0] want;
`ifdef BTB_FWD_EN
    want = {1'b1, 1'b1, 16'h0400};
`else
    want = {1'b0, 1'b0, 16'h0032};
`endif
    drive(16'h0030, 1'b1, 16'h0030, 1'b1, 16'h0400);
    #1;
    n_checks++;
    if ({lk_hit, lk_taken, lk_next} !== want) begin
      n_fail++;
      $display("FAIL simul_same_cycle: got %b %b %h want %h", lk_hit, lk_taken, lk_next, want);
    end
    tick();
    drive(16'h0030, 1'b0, 16'h0, 1'b0, 16'h0);
    #1;
    n_checks++;
    if ({lk_hit, lk_taken, lk_next} !== {1'b1, 1'b1, 16'h0400}) begin
      n_fail++;
      $display("FAIL simul_next_cycle: got %b %b %h want 1 1 0400", lk_hit, lk_taken, lk_next);
    end
    tick();
  endtask

  task automatic test_midclear();
    logic [15:0] pcs[$];
    logic [15:0] p;
    logic eh, et; logic [15:0] en;
    int cnt = 0;
    drive(16'h0010, 1'b0, 16'h0, 1'b0, 16'h0);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1;
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL midclear_pre cyc %0d: got busy=%b want 1", k, busy);
      end
      tick();
    end
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      p = 16'(($urandom_range(0, 7) << 5) | ($urandom_range(0, 15) << 1));
      pcs.push_back(p);
      drive(p, 1'b1, p, 1'b1, 16'(($urandom_range(0, 16'h7FFF)) << 1));
      #1; expect_lookup(eh, et, en);
      n_checks++;
      if ({busy, lk_hit, lk_taken, lk_next} !== {m_clear_left > 0, eh, et, en}) begin
        n_fail++;
        $display("FAIL midclear_busy cyc %0d: got %b %b %b %h want %b %b %b %h",
                 k, busy, lk_hit, lk_taken, lk_next, m_clear_left > 0, eh, et, en);
      end
      if (busy !== 1'b1) begin
        void'(pcs.pop_back());
        break;
      end
      cnt++;
      tick();
    end
    n_checks++;
    if (cnt !== 16) begin
      n_fail++;
      $display("FAIL midclear_len: got %0d cycles want 16", cnt);
    end
    upd_en = 1'b0;
    foreach (pcs[j]) begin
      lk_pc = pcs[j];
      #1;
      n_checks++;
      if ({lk_hit, lk_next} !== {1'b0, pcs[j] + 16'd2}) begin
        n_fail++;
        $display("FAIL midclear_dropped pc=%h: got %b %h want 0 %h", pcs[j], lk_hit, lk_next, pcs[j] + 16'd2);
      end
    end
    tick();
  endtask

  task automatic test_random();
    logic eh, et; logic [15:0] en;
    logic [15:0] up;
    for (int k = 0; k < 500; k++) begin
      up = 16'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 3) << 1) | ($urandom_range(0, 255) << 8));
      drive(($urandom_range(0, 1) == 1) ? up
              : 16'(($urandom_range(0, 3) << 5) | ($urandom_range(0, 3) << 1) | ($urandom_range(0, 255) << 8)),
            $urandom_range(0, 9) < 7, up, $urandom_range(0, 9) < 6,
            16'($urandom_range(0, 16'h7FFF) << 1));
      #1; expect_lookup(eh, et, en);
      n_checks++;
      if ({busy, lk_hit, lk_taken, lk_next} !== {m_clear_left > 0, eh, et, en}) begin
        n_fail++;
        $display("FAIL random cyc %0d pc=%h: got %b %b %b %h want %b %b %b %h",
                 k, lk_pc, busy, lk_hit, lk_taken, lk_next, m_clear_left > 0, eh, et, en);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_hysteresis();
    test_alias();
    test_wrap();
    test_simultaneous();
    test_midclear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
